// File: rtl/video_pattern_pkg.sv
// Shared types, bar colour table and mask expansion helper for the
// video test-pattern generator.
package video_pattern_pkg;

    typedef enum logic [2:0] {
        PAT_COUNT = 3'd0,
        PAT_BARS  = 3'd1,
        PAT_RAMP  = 3'd2,
        PAT_CHECK = 3'd3,
        PAT_SOLID = 3'd4
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } run_state_e;

    localparam int MAX_CSIZE = 16;
    localparam int MAX_DSIZE = 3 * MAX_CSIZE;

    // {R,G,B} masks: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_MASK [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [MAX_DSIZE-1:0] expand_mask(input logic [2:0] mask,
                                                         input int        csize);
        logic [MAX_DSIZE-1:0] ones;
        logic [MAX_DSIZE-1:0] res;
        ones = {MAX_DSIZE{1'b1}} >> (MAX_DSIZE - csize);
        res  = {MAX_DSIZE{1'b0}};
        if (mask[2]) res = res | (ones << (2 * csize));
        if (mask[1]) res = res | (ones << csize);
        if (mask[0]) res = res | ones;
        return res;
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster timing generator: h/v counters, sync and active decode, and the
// run / stop-pending / idle control that lets a frame finish before stopping.
module video_timing_core
    import video_pattern_pkg::*;
#(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        pclk,
    input  logic        prst_n,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        sof,
    output logic        frame_start,
    output logic        frame_end,
    output logic [15:0] x,
    output logic [15:0] y
);

    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int H_TOTAL = H_END + H_FP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam int V_TOTAL = V_END + V_FP;

    run_state_e  state_r;
    run_state_e  state_s;
    logic [15:0] hcnt_r;
    logic [15:0] vcnt_r;
    logic        running_s;
    logic        h_last_s;
    logic        v_last_s;
    logic        last_pos_s;
    logic        h_act_s;
    logic        v_act_s;

    assign running_s  = (state_r != ST_IDLE);
    assign h_last_s   = (hcnt_r == 16'(H_TOTAL - 1));
    assign v_last_s   = (vcnt_r == 16'(V_TOTAL - 1));
    assign last_pos_s = running_s && h_last_s && v_last_s;

    // Next-state logic; a stop request only takes effect at the frame's last position
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_s = ST_RUN;
                else        state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_s = last_pos_s ? ST_IDLE : ST_STOP_PEND;
                else         state_s = ST_RUN;
            end
            ST_STOP_PEND: begin
                if (enable)          state_s = ST_RUN;
                else if (last_pos_s) state_s = ST_IDLE;
                else                 state_s = ST_STOP_PEND;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) state_r <= ST_IDLE;
        else         state_r <= state_s;
    end

    // Raster counters, parked at the origin while idle
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            hcnt_r <= 16'd0;
            vcnt_r <= 16'd0;
        end else if (!running_s) begin
            hcnt_r <= 16'd0;
            vcnt_r <= 16'd0;
        end else if (h_last_s) begin
            hcnt_r <= 16'd0;
            vcnt_r <= v_last_s ? 16'd0 : vcnt_r + 16'd1;
        end else begin
            hcnt_r <= hcnt_r + 16'd1;
        end
    end

    // Sync and active-region decode of the current counter state
    always_comb begin
        h_act_s     = (hcnt_r >= 16'(H_START)) && (hcnt_r < 16'(H_END));
        v_act_s     = (vcnt_r >= 16'(V_START)) && (vcnt_r < 16'(V_END));
        hsync       = (running_s && (hcnt_r < 16'(H_SYNC))) ? SYNC_POL : ~SYNC_POL;
        vsync       = (running_s && (vcnt_r < 16'(V_SYNC))) ? SYNC_POL : ~SYNC_POL;
        de          = running_s && h_act_s && v_act_s;
        x           = hcnt_r - 16'(H_START);
        y           = vcnt_r - 16'(V_START);
        sof         = de && (x == 16'd0) && (y == 16'd0);
        frame_start = (hcnt_r == 16'd0) && (vcnt_r == 16'd0);
        frame_end   = last_pos_s;
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Self-timed video test-pattern source: counter, colour bars, ramp,
// checkerboard and solid colour on a registered native video stream.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int   CSIZE    = 8,
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic SYNC_POL = 1'b1,
    parameter int   CHK_LOG2 = 4,
    localparam int  DSIZE    = 3 * CSIZE
) (
    input  logic             pclk,
    input  logic             prst_n,
    input  logic             enable,
    input  logic [2:0]       pattern,
    input  logic [DSIZE-1:0] solid_rgb,
    output logic             vsync,
    output logic             hsync,
    output logic             de,
    output logic [DSIZE-1:0] data,
    output logic [15:0]      vactive,
    output logic [15:0]      hactive,
    output logic [15:0]      frame_cnt,
    output logic             sof
);

    localparam int          BAR_W    = H_ACTIVE / 8;
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    logic                 t_hsync;
    logic                 t_vsync;
    logic                 t_de;
    logic                 t_sof;
    logic                 t_frame_start;
    logic                 t_frame_end;
    logic [15:0]          t_x;
    logic [15:0]          t_y;
    pattern_e             pattern_r;
    logic [DSIZE-1:0]     solid_r;
    logic [2:0]           bar_idx_r;
    logic [15:0]          bar_pix_r;
    logic [MAX_DSIZE-1:0] bar_rgb_s;
    logic [DSIZE-1:0]     pix_s;

    assign vactive = 16'(V_ACTIVE);
    assign hactive = 16'(H_ACTIVE);

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .pclk        (pclk),
        .prst_n      (prst_n),
        .enable      (enable),
        .hsync       (t_hsync),
        .vsync       (t_vsync),
        .de          (t_de),
        .sof         (t_sof),
        .frame_start (t_frame_start),
        .frame_end   (t_frame_end),
        .x           (t_x),
        .y           (t_y)
    );

    // Pattern selection is frozen at the frame origin so a frame never mixes patterns
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pattern_r <= PAT_COUNT;
            solid_r   <= {DSIZE{1'b0}};
        end else if (t_frame_start) begin
            pattern_r <= (pattern > 3'd4) ? PAT_COUNT : pattern_e'(pattern);
            solid_r   <= solid_rgb;
        end else begin
            pattern_r <= pattern_r;
            solid_r   <= solid_r;
        end
    end

    // Bar index tracks x by counting pixels; the last bar soaks up any remainder
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            bar_idx_r <= 3'd0;
            bar_pix_r <= 16'd0;
        end else if (!t_de) begin
            bar_idx_r <= 3'd0;
            bar_pix_r <= 16'd0;
        end else if (bar_pix_r == BAR_LAST) begin
            bar_pix_r <= 16'd0;
            bar_idx_r <= (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
        end else begin
            bar_pix_r <= bar_pix_r + 16'd1;
        end
    end

    // Pixel value for the current counter position
    always_comb begin
        bar_rgb_s = expand_mask(BAR_MASK[bar_idx_r], CSIZE);
        pix_s     = {DSIZE{1'b0}};
        case (pattern_r)
            PAT_COUNT: pix_s = DSIZE'(t_x);
            PAT_BARS:  pix_s = bar_rgb_s[DSIZE-1:0];
            PAT_RAMP:  pix_s = {3{t_x[CSIZE-1:0]}};
            PAT_CHECK: pix_s = (t_x[CHK_LOG2] ^ t_y[CHK_LOG2]) ? {DSIZE{1'b1}} : {DSIZE{1'b0}};
            PAT_SOLID: pix_s = solid_r;
            default:   pix_s = DSIZE'(t_x);
        endcase
    end

    // Output stage: all stream outputs registered together to stay aligned
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            de        <= 1'b0;
            data      <= {DSIZE{1'b0}};
            sof       <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            hsync     <= t_hsync;
            vsync     <= t_vsync;
            de        <= t_de;
            data      <= t_de ? pix_s : {DSIZE{1'b0}};
            sof       <= t_sof;
            frame_cnt <= t_frame_end ? frame_cnt + 16'd1 : frame_cnt;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed and randomised bench for video_pattern_gen using a small raster
// model driven by frame position arithmetic.
module tb_video_pattern_gen;

    localparam int HT = 22;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic        enable;
    logic [2:0]  pattern;
    logic [23:0] solid_rgb;
    logic        vsync, hsync, de, sof;
    logic [23:0] data;
    logic [15:0] vactive, hactive, frame_cnt;

    int total = 0;
    int bad   = 0;

    // model state: running flag, position within frame, frame count, latched pattern
    bit          m_run;
    int          m_pos;
    int          m_frames;
    int          m_pat;
    logic [23:0] m_solid;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    video_pattern_gen #(
        .CSIZE (8), .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1), .CHK_LOG2 (1)
    ) dut (
        .pclk (pclk), .prst_n (prst_n), .enable (enable), .pattern (pattern),
        .solid_rgb (solid_rgb), .vsync (vsync), .hsync (hsync), .de (de),
        .data (data), .vactive (vactive), .hactive (hactive),
        .frame_cnt (frame_cnt), .sof (sof)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int x, input int y, input int pat,
                                            input logic [23:0] solid);
        logic [7:0] xb;
        int         bi;
        xb = 8'(x);
        bi = (x / 2 > 7) ? 7 : x / 2;
        case (pat)
            1:       return bars[bi];
            2:       return {xb, xb, xb};
            3:       return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            4:       return solid;
            default: return 24'(x);
        endcase
    endfunction

    // one clock: predict outputs from the pre-edge position, advance the model, compare
    task automatic tick();
        logic        e_hs, e_vs, e_de, e_sof, latch;
        logic [23:0] e_data;
        int          h, v, x, y;
        @(posedge pclk);
        h = m_pos % HT;
        v = m_pos / HT;
        x = h - 4;
        y = v - 2;
        e_hs   = m_run && (h < 2);
        e_vs   = m_run && (v < 1);
        e_de   = m_run && (h >= 4) && (h < 20) && (v >= 2) && (v < 6);
        e_data = e_de ? exp_pix(x, y, m_pat, m_solid) : 24'h0;
        e_sof  = e_de && (x == 0) && (y == 0);
        latch  = !m_run || (m_pos == 0);
        if (m_run) begin
            if (m_pos == FT - 1) begin
                m_frames = (m_frames + 1) % 65536;
                m_pos    = 0;
                if (!enable) m_run = 1'b0;
            end else begin
                m_pos++;
            end
        end else if (enable) begin
            m_run = 1'b1;
        end
        if (latch) begin
            m_pat   = (pattern > 3'd4) ? 0 : int'(pattern);
            m_solid = solid_rgb;
        end
        #1;
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("data", 32'(data), 32'(e_data));
        chk("sof", 32'(sof), 32'(e_sof));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 2 * FT && !(m_run && m_pos == p); i++) tick();
    endtask

    initial begin
        int          k;
        bit          seen;
        int          frozen;
        prst_n    = 1'b0;
        enable    = 1'b0;
        pattern   = 3'd0;
        solid_rgb = 24'h0;
        m_run     = 1'b0;
        m_pos     = 0;
        m_frames  = 0;
        m_pat     = 0;
        m_solid   = 24'h0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_sof", 32'(sof), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("vactive", 32'(vactive), 32'd4);
        chk("hactive", 32'(hactive), 32'd16);
        @(negedge pclk);
        prst_n = 1'b1;
        repeat (3) tick();

        // counter pattern timing over two frames
        enable = 1'b1;
        repeat (2 * FT + 2) tick();
        chk("fcnt_after_2", 32'(frame_cnt), 32'd2);

        // bars, checker, ramp: each gets one full frame after latching
        pattern = 3'd1; repeat (2 * FT) tick();
        pattern = 3'd3; repeat (2 * FT) tick();
        pattern = 3'd2; repeat (2 * FT) tick();

        // switch to solid in the middle of a counter frame
        pattern = 3'd0;
        run_to(0);
        run_to(2 * HT + 5);
        pattern   = 3'd4;
        solid_rgb = 24'h123456;
        repeat (2 * FT) tick();

        // stop request on line 1, frame completes, then idle with count frozen
        run_to(HT + 3);
        enable = 1'b0;
        for (int i = 0; i < 2 * FT && m_run; i++) tick();
        frozen = m_frames;
        repeat (30) tick();
        chk("fcnt_frozen", 32'(frame_cnt), 32'(frozen));

        // restart: first sof 2*22+5 clocks after the restart edge
        enable = 1'b1;
        k      = 0;
        seen   = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (sof === 1'b1) seen = 1'b1;
            else              k++;
        end
        chk("restart_sof", 32'(k), 32'd49);

        // asynchronous reset during an active pixel
        run_to(3 * HT + 10);
        #3;
        prst_n = 1'b0;
        #1;
        chk("arst_de", 32'(de), 32'd0);
        chk("arst_data", 32'(data), 32'd0);
        chk("arst_hsync", 32'(hsync), 32'd0);
        chk("arst_vsync", 32'(vsync), 32'd0);
        chk("arst_fcnt", 32'(frame_cnt), 32'd0);
        m_run    = 1'b0;
        m_pos    = 0;
        m_frames = 0;
        m_pat    = 0;
        m_solid  = 24'h0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        repeat (2 * FT) tick();

        // randomised pattern/colour changes and enable toggling
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(0, 99) < 3) pattern = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 3) solid_rgb = 24'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Parametrised successor to the fixed-mode test-data source. It contains its own timing generator, set by parameters, and produces run-time selectable test patterns on a video native stream: pixel counter, 8-colour bars, horizontal ramp, checkerboard and solid colour. It sits at the head of the VDMA write path as a stimulus and bring-up source, and reports active size and a frame count.

Parameters:
CSIZE, 8, bits per colour component; DSIZE = 3*CSIZE, packed {R,G,B}
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (clocks)
H_SYNC, 44, hsync width (clocks)
H_BP, 148, horizontal back porch (clocks)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
SYNC_POL, 1'b1, active level of hsync and vsync
CHK_LOG2, 4, checker square size = 2**CHK_LOG2 pixels/lines

Ports:
pclk  in  1  pixel clock
prst_n  in  1  asynchronous active-low reset
enable  in  1  run request
pattern  in  3  0 counter, 1 bars, 2 ramp, 3 checker, 4 solid, 5-7 treated as 0
solid_rgb  in  DSIZE  colour used by pattern 4
vsync  out  1  vertical sync, level SYNC_POL
hsync  out  1  horizontal sync, level SYNC_POL
de  out  1  active video
data  out  DSIZE  pixel data {R,G,B}
vactive  out  16  V_ACTIVE constant
hactive  out  16  H_ACTIVE constant
frame_cnt  out  16  completed-frame count
sof  out  1  one-cycle pulse on the first active pixel of a frame

Behaviour:
- Reset: hcnt=vcnt=0, running=0, syncs=~SYNC_POL, de=0, data=0, sof=0, frame_cnt=0. vactive and hactive are constants and unaffected by reset.
- Line timing: hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters). hsync is active for hcnt<H_SYNC. Active region is H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE; FP follows. vcnt increments when hcnt wraps and uses the same ordering with the V_* parameters.
- de is high only when both the horizontal and vertical counters are in their active regions.
- Latency: every output is registered, one pclk after the counter state. All outputs stay mutually aligned.
- States: IDLE -> RUN when enable=1; counters start at (0,0). RUN -> STOP_PEND when enable=0 mid-frame. STOP_PEND finishes the current frame, then enters IDLE at the last vcnt/hcnt.
- In STOP_PEND, enable=1 returns to RUN with no gap. In IDLE, counters are held at 0, syncs inactive, de=0, data=0.
- Pattern and solid_rgb are sampled at hcnt=vcnt=0 and held for the whole frame. Values 5-7 decode as 0.
- x = active pixel index 0..H_ACTIVE-1; y = active line 0..V_ACTIVE-1.
- Pattern 0: data = x, zero-extended/truncated to DSIZE.
- Pattern 1: BAR_W = H_ACTIVE/8, integer. The bar index is held by a counter, not a divider, and saturates at 7; the last bar absorbs the remainder. Order: white, yellow, cyan, green, magenta, red, blue, black. Components are all-ones or 0.
- Pattern 2: R=G=B=x[CSIZE-1:0], wrapping modulo 2**CSIZE.
- Pattern 3: all components are all-ones when x[CHK_LOG2]^y[CHK_LOG2]=1, else 0.
- Pattern 4: data = latched solid_rgb.
- data=0 whenever de=0.
- sof: high together with de at x=0, y=0.
- frame_cnt: +1 on each completed frame (last counter position), wraps 0xFFFF->0.
- Async reset mid-frame: all outputs return immediately to reset values.

Decomposition:
- Package video_pattern_pkg: pattern_e enum (PAT_COUNT, PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_SOLID), 8-entry bar colour table as 3-bit RGB masks, and a function expanding a mask to DSIZE.
- Sub-module video_timing_core: counters, sync/de decode, x/y and frame-end flags, RUN/STOP_PEND/IDLE state machine. The top level holds pattern latching and the data mux/registers.

Test Plan:
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1; H_TOTAL=22, frame = 154 clocks; CSIZE=8, CHK_LOG2=1.
1. Timing: enable=1, pattern=0 -> hsync 2 clocks per 22; de 16 clocks per line on 4 lines per frame; vsync 22 clocks; sof once per 154; data 0..15 on every line; frame_cnt=1 after the first frame.
2. Bars: pattern=1, BAR_W=2 -> data sequence FFFFFF x2, FFFF00 x2, 00FFFF x2, 00FF00 x2, FF00FF x2, FF0000 x2, 0000FF x2, 000000 x2.
3. Checker/ramp: pattern=3 -> line y=0 gives 000000 x2, FFFFFF x2, repeating; line y=2 gives the inverse. pattern=2 -> data = 0x000000, 0x010101 ... 0x0F0F0F.
4. Mid-frame change: switch pattern 0->4 (solid_rgb=0x123456) at line 2 -> current frame stays counter; next frame all 0x123456.
5. Stop/restart: drop enable on line 1 -> frame completes (4 de lines), then outputs idle and frame_cnt is frozen. Re-raise enable -> first sof 2*22+5 clocks after the restart edge.
6. Async reset at mid-line -> de=0, data=0, syncs inactive and frame_cnt=0 in the same cycle; clean frame after release.
